lpc: RTL and testbench
======================

// Module: lpc
// PURPOSE
//  Passive LPC bus sniffer: samples LAD[3:0]/LFRAME# on the LPC clock and decodes I/O and memory
//  read/write cycles. Each completed cycle is reported as cycle type/direction, address and data,
//  qualified by a one-cycle strobe. Drives nothing onto the bus; feeds a downstream capture/FIFO stage.
// PARAMETERS
//  (none)
// PORTS
//  lpc_clock         in   1   LPC clock; all logic on rising edge. One clock domain.
//  lpc_reset         in   1   LRESET#, synchronous, active-low; lpc_clock is the only clock.
//  lpc_ad            in   4   LAD[3:0], sampled only
//  lpc_frame         in   1   LFRAME#, active-low start/abort
//  out_cyctype_dir   out  4   captured CT/DIR nibble: [3:2] 00=I/O 01=mem, [1] 0=read 1=write, [0]=0
//  out_addr          out  32  address; I/O zero-extended from 16 bits
//  out_data          out  32  data; byte in [7:0], [31:8]=0
//  out_data_size     out  3   bytes transferred; always 1
//  out_clock_enable  out  1   one-cycle strobe: out_* hold a completed cycle
// BEHAVIOUR
//  - Reset (lpc_reset=0 at a rising edge): state IDLE, all outputs 0, counters 0.
//  - Start: any edge with lpc_frame=0 loads START and latches lpc_ad; the last frame-low nibble is
//    the start code. First edge with frame=1: if start code!=0000 -> IDLE; else nibble = CT/DIR.
//  - CT/DIR: ad[3:2]=00 (I/O) -> 4 address nibbles; 01 (mem) -> 8 address nibbles; 10/11 (DMA,
//    reserved) -> IDLE, nothing reported. Address nibbles MSB first, shifted in one per clock.
//  - Read:  ADDR -> TAR(2) -> SYNC -> DATA(2) -> TAR(2).
//    Write: ADDR -> DATA(2) -> TAR(2) -> SYNC -> TAR(2).
//  - DATA: two nibbles, low nibble first (data[3:0] then data[7:4]).
//  - SYNC: 0000 ready -> next phase; 0101 short wait / 0110 long wait -> stay in SYNC, no limit;
//    1010 error or any other code -> IDLE, nothing reported.
//  - Completion: at the edge sampling the 2nd nibble of the final TAR, register out_cyctype_dir,
//    out_addr, out_data, out_data_size=1 and set out_clock_enable=1 for exactly one clock; cleared
//    next edge. out_* data hold until the next completion or reset.
//  - TAR nibble values are ignored (normally 1111/ZZZZ).
//  - lpc_frame=0 during any non-IDLE state aborts: cycle discarded, no strobe, re-enter START.
//    lpc_frame=0 at the completion edge likewise suppresses the strobe.
//  - Reset mid-cycle: immediate return to IDLE, outputs cleared, no strobe.
//  - Back-to-back cycles: a new START may begin the edge after the final TAR.
// STRUCTURE
//  - Shared package lpc_pkg: FSM state enum (IDLE, START, CTDIR, ADDR, TAR_A, SYNC, DATA, TAR_B),
//    cycle-type codes (CT_IO=2'b00, CT_MEM=2'b01), DIR bit index, sync codes (SYNC_READY=4'h0,
//    SYNC_SHORT=4'h5, SYNC_LONG=4'h6, SYNC_ERR=4'hA), start code START_TARGET=4'h0.
//  - Single flat module: one FSM, one 3-bit nibble counter, address/data shift registers. No
//    sub-modules.
// TESTING
//  - I/O read: start 0000, CT 0000, addr 7fe5, TAR, sync 0000, data 6c (c,6), TAR -> one strobe,
//    addr=0x7fe5, data=0x6c, size=1, ctdir=0.
//  - I/O write: CT 0010, addr 0080, data a5, TAR, sync 0000, TAR -> one strobe, addr=0x80,
//    data=0xa5, ctdir=2.
//  - Mem read: CT 0100, addr 12345678, data 3c -> addr=0x12345678, data=0x3c, ctdir=4.
//  - Waits: I/O read with sync 0110 x3 then 0000 -> same results as case 1; sync 1010 -> no strobe.
//  - Abort: frame low mid-address, then a full I/O read of 0x7fe5 -> exactly one strobe, for 0x7fe5.
//  - Reset: lpc_reset=0 during DATA -> outputs 0, no strobe; next clean cycle reports normally.

Source files
------------

// File: rtl/lpc_pkg.sv
// lpc_pkg: shared definitions for the passive LPC bus sniffer.
//   - lpc_state_t : FSM phases of an LPC I/O or memory cycle
//   - CT_*        : cycle-type codes found in CT/DIR nibble bits [3:2]
//   - DIR_BIT     : CT/DIR bit that selects write (1) or read (0)
//   - SYNC_*      : SYNC nibble codes
//   - START_TARGET: start code of a host-initiated target cycle
package lpc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CTDIR,
    ADDR,
    TAR_A,
    SYNC,
    DATA,
    TAR_B
  } lpc_state_t;

  localparam logic [1:0] CT_IO  = 2'b00;
  localparam logic [1:0] CT_MEM = 2'b01;

  localparam int DIR_BIT = 1;

  localparam logic [3:0] SYNC_READY   = 4'h0;
  localparam logic [3:0] SYNC_SHORT   = 4'h5;
  localparam logic [3:0] SYNC_LONG    = 4'h6;
  localparam logic [3:0] SYNC_ERR     = 4'hA;
  localparam logic [3:0] START_TARGET = 4'h0;

  // Counter preload for the address phase: it counts down to zero, so
  // an I/O cycle (4 nibbles) starts at 3 and a memory cycle (8) at 7.
  function automatic logic [2:0] addr_last(input logic [1:0] cyc_type);
    return (cyc_type == CT_MEM) ? 3'd7 : 3'd3;
  endfunction

endpackage

// File: rtl/lpc.sv
// lpc: passive LPC bus sniffer. Samples LAD/LFRAME# on every rising edge
// of lpc_clock, follows I/O and memory read/write cycles and reports each
// completed cycle with a one-clock strobe. Never drives the bus.
//
// Ports:
//   lpc_clock        in   LPC clock, only clock domain
//   lpc_reset        in   LRESET#, synchronous, active-low
//   lpc_ad[3:0]      in   LAD[3:0]
//   lpc_frame        in   LFRAME#, active-low start/abort
//   out_cyctype_dir  out  CT/DIR nibble of the reported cycle (bit 0 forced 0)
//   out_addr[31:0]   out  cycle address, I/O addresses zero-extended
//   out_data[31:0]   out  data byte in [7:0]
//   out_data_size    out  bytes transferred (always 1)
//   out_clock_enable out  one-clock strobe marking a freshly reported cycle
module lpc
  import lpc_pkg::*;
(
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  lpc_ad,
  input  logic        lpc_frame,
  output logic [3:0]  out_cyctype_dir,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [2:0]  out_data_size,
  output logic        out_clock_enable
);

  lpc_state_t state, state_next;
  logic [2:0] cnt, cnt_next;

  logic [3:0]  ctdir;
  logic [31:0] addr;
  logic [7:0]  data;

  logic load_ct;
  logic shift_addr;
  logic load_lo;
  logic load_hi;
  logic complete;
  logic is_write;

  assign is_write = ctdir[DIR_BIT];

  // State register and the shared nibble counter. The counter always
  // counts down so every multi-nibble phase ends when it reaches zero.
  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. LFRAME# low overrides everything: the current cycle
  // is dropped and the nibble is taken as a start code. A target start
  // code goes straight to CTDIR so that the first frame-high nibble is
  // decoded as CT/DIR; any other start code parks in START and falls back
  // to IDLE once the frame is released.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_ct    = 1'b0;
    shift_addr = 1'b0;
    load_lo    = 1'b0;
    load_hi    = 1'b0;
    complete   = 1'b0;

    if (!lpc_frame) begin
      state_next = (lpc_ad == START_TARGET) ? CTDIR : START;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        START: state_next = IDLE;
        CTDIR: begin
          case (lpc_ad[3:2])
            CT_IO, CT_MEM: begin
              load_ct    = 1'b1;
              cnt_next   = addr_last(lpc_ad[3:2]);
              state_next = ADDR;
            end
            default: state_next = IDLE;
          endcase
        end
        ADDR: begin
          shift_addr = 1'b1;
          if (cnt == 3'd0) begin
            cnt_next   = 3'd1;
            state_next = is_write ? DATA : TAR_A;
          end else begin
            cnt_next = cnt - 3'd1;
          end
        end
        // TAR_A always leads to SYNC: after the address on reads, after
        // the host data on writes.
        TAR_A: begin
          if (cnt == 3'd0) begin
            state_next = SYNC;
          end else begin
            cnt_next = cnt - 3'd1;
          end
        end
        SYNC: begin
          case (lpc_ad)
            SYNC_READY: begin
              cnt_next   = 3'd1;
              state_next = is_write ? TAR_B : DATA;
            end
            SYNC_SHORT, SYNC_LONG: state_next = SYNC;
            default: state_next = IDLE;
          endcase
        end
        DATA: begin
          if (cnt == 3'd1) begin
            load_lo  = 1'b1;
            cnt_next = 3'd0;
          end else begin
            load_hi    = 1'b1;
            cnt_next   = 3'd1;
            state_next = is_write ? TAR_A : TAR_B;
          end
        end
        TAR_B: begin
          if (cnt == 3'd0) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt - 3'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Capture registers. Address and data are cleared when CT/DIR is
  // accepted so a 16-bit I/O address ends up zero-extended.
  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      ctdir <= 4'h0;
      addr  <= 32'h0;
      data  <= 8'h0;
    end else begin
      if (load_ct) begin
        ctdir <= {lpc_ad[3:1], 1'b0};
        addr  <= 32'h0;
        data  <= 8'h0;
      end
      if (shift_addr) addr <= {addr[27:0], lpc_ad};
      if (load_lo) data[3:0] <= lpc_ad;
      if (load_hi) data[7:4] <= lpc_ad;
    end
  end

  // Report registers: updated only on completion and held until the next
  // one; the strobe follows the completion flag for a single clock.
  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      out_cyctype_dir  <= 4'h0;
      out_addr         <= 32'h0;
      out_data         <= 32'h0;
      out_data_size    <= 3'd0;
      out_clock_enable <= 1'b0;
    end else begin
      out_clock_enable <= complete;
      if (complete) begin
        out_cyctype_dir <= ctdir;
        out_addr        <= addr;
        out_data        <= {24'h0, data};
        out_data_size   <= 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_lpc.sv
// tb_lpc: directed scoreboard bench for the LPC sniffer. Each bus cycle
// pushes its expected report into a queue; every strobe pops and checks it.
module tb_lpc;

  logic        lpc_clock;
  logic        lpc_reset;
  logic [3:0]  lpc_ad;
  logic        lpc_frame;
  logic [3:0]  out_cyctype_dir;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [2:0]  out_data_size;
  logic        out_clock_enable;

  typedef struct packed {
    logic [3:0]  ctdir;
    logic [31:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   vectors;
  int   miscompares;

  lpc dut (
    .lpc_clock        (lpc_clock),
    .lpc_reset        (lpc_reset),
    .lpc_ad           (lpc_ad),
    .lpc_frame        (lpc_frame),
    .out_cyctype_dir  (out_cyctype_dir),
    .out_addr         (out_addr),
    .out_data         (out_data),
    .out_data_size    (out_data_size),
    .out_clock_enable (out_clock_enable)
  );

  initial lpc_clock = 1'b0;
  always #5 lpc_clock = ~lpc_clock;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called #1 after each rising edge: a strobe must match the oldest
  // queued expectation, and a strobe with nothing queued is an error.
  task automatic checkOutput();
    exp_t e;
    if (out_clock_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkValue("spurious_strobe", 32'(out_clock_enable), 32'd0);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        checkValue("ctdir", 32'(out_cyctype_dir), 32'(e.ctdir));
        checkValue("addr", out_addr, e.addr);
        checkValue("data", out_data, {24'h0, e.data});
        checkValue("size", 32'(out_data_size), 32'd1);
      end
    end
  endtask

  // Drive one nibble at the falling edge, let the DUT sample it, check.
  task automatic applyStimulus(input logic frame, input logic [3:0] ad);
    @(negedge lpc_clock);
    lpc_frame = frame;
    lpc_ad    = ad;
    @(posedge lpc_clock);
    #1;
    checkOutput();
  endtask

  // Full LPC cycle. waits = number of long-wait SYNC nibbles before
  // sync_code; a non-ready sync_code ends the cycle there. abort_last
  // pulls LFRAME# low on the final TAR nibble.
  task automatic lpcCycle(input logic [3:0] ctdir, input logic [31:0] addr,
                          input logic [7:0] data, input int waits,
                          input logic [3:0] sync_code, input bit abort_last);
    int   n;
    exp_t e;
    n = ctdir[2] ? 8 : 4;
    e.ctdir = ctdir;
    e.addr  = ctdir[2] ? addr : {16'h0, addr[15:0]};
    e.data  = data;
    applyStimulus(1'b0, 4'h0);
    applyStimulus(1'b1, ctdir);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, addr[i*4 +: 4]);
    if (ctdir[1]) begin
      applyStimulus(1'b1, data[3:0]);
      applyStimulus(1'b1, data[7:4]);
      applyStimulus(1'b1, 4'hF);
      applyStimulus(1'b1, 4'hF);
    end else begin
      applyStimulus(1'b1, 4'hF);
      applyStimulus(1'b1, 4'hF);
    end
    for (int w = 0; w < waits; w++) applyStimulus(1'b1, 4'h6);
    applyStimulus(1'b1, sync_code);
    if (sync_code == 4'h0) begin
      if (!ctdir[1]) begin
        applyStimulus(1'b1, data[3:0]);
        applyStimulus(1'b1, data[7:4]);
      end
      applyStimulus(1'b1, 4'hF);
      if (!abort_last) exp_q.push_back(e);
      applyStimulus(abort_last ? 1'b0 : 1'b1, 4'hF);
    end
  endtask

  task automatic checkDrained(input string tag);
    checkValue(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkCleared(input string tag);
    checkValue({tag, "_strobe"}, 32'(out_clock_enable), 32'd0);
    checkValue({tag, "_ctdir"}, 32'(out_cyctype_dir), 32'd0);
    checkValue({tag, "_addr"}, out_addr, 32'd0);
    checkValue({tag, "_data"}, out_data, 32'd0);
    checkValue({tag, "_size"}, 32'(out_data_size), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_exp    = '0;
    lpc_reset   = 1'b0;
    lpc_frame   = 1'b1;
    lpc_ad      = 4'hF;
    repeat (2) @(posedge lpc_clock);
    #1;
    checkCleared("reset");
    @(negedge lpc_clock);
    lpc_reset = 1'b1;

    $display("[TB] I/O read 0x7fe5");
    lpcCycle(4'h0, 32'h7fe5, 8'h6c, 0, 4'h0, 1'b0);
    checkDrained("io_read_strobe");
    applyStimulus(1'b1, 4'hF);
    checkValue("hold_addr", out_addr, last_exp.addr);

    $display("[TB] I/O write 0x0080");
    lpcCycle(4'h2, 32'h0080, 8'ha5, 0, 4'h0, 1'b0);
    checkDrained("io_write_strobe");

    $display("[TB] back-to-back mem read then mem write");
    lpcCycle(4'h4, 32'h12345678, 8'h3c, 0, 4'h0, 1'b0);
    lpcCycle(4'h6, 32'h89abcdef, 8'h5a, 0, 4'h0, 1'b0);
    checkDrained("b2b_strobe");
    applyStimulus(1'b1, 4'hF);
    checkValue("hold_data", out_data, {24'h0, last_exp.data});

    $display("[TB] long waits then ready");
    lpcCycle(4'h0, 32'h7fe5, 8'h6c, 3, 4'h0, 1'b0);
    checkDrained("wait_strobe");

    $display("[TB] sync error and DMA type");
    lpcCycle(4'h0, 32'h1234, 8'h11, 1, 4'hA, 1'b0);
    repeat (4) applyStimulus(1'b1, 4'h0);
    applyStimulus(1'b0, 4'h0);
    applyStimulus(1'b1, 4'h8);
    repeat (10) applyStimulus(1'b1, 4'h0);
    checkDrained("no_strobe_err_dma");

    $display("[TB] bad start code");
    applyStimulus(1'b0, 4'h5);
    applyStimulus(1'b1, 4'h0);
    repeat (12) applyStimulus(1'b1, 4'h0);
    checkValue("bad_start_addr", out_addr, last_exp.addr);

    $display("[TB] abort mid-address then I/O read");
    applyStimulus(1'b0, 4'h0);
    applyStimulus(1'b1, 4'h0);
    applyStimulus(1'b1, 4'h1);
    applyStimulus(1'b1, 4'h2);
    lpcCycle(4'h0, 32'h7fe5, 8'h6c, 0, 4'h0, 1'b0);
    checkDrained("abort_strobe");

    $display("[TB] frame low on completion edge");
    lpcCycle(4'h2, 32'h4321, 8'h77, 0, 4'h0, 1'b1);
    repeat (2) applyStimulus(1'b1, 4'hF);
    checkValue("abort_last_addr", out_addr, 32'h00007fe5);

    $display("[TB] reset during DATA");
    applyStimulus(1'b0, 4'h0);
    applyStimulus(1'b1, 4'h0);
    applyStimulus(1'b1, 4'hb);
    applyStimulus(1'b1, 4'he);
    applyStimulus(1'b1, 4'he);
    applyStimulus(1'b1, 4'hf);
    applyStimulus(1'b1, 4'hF);
    applyStimulus(1'b1, 4'hF);
    applyStimulus(1'b1, 4'h0);
    applyStimulus(1'b1, 4'h9);
    @(negedge lpc_clock);
    lpc_reset = 1'b0;
    @(posedge lpc_clock);
    #1;
    checkCleared("mid_reset");
    @(negedge lpc_clock);
    lpc_reset = 1'b1;
    repeat (3) applyStimulus(1'b1, 4'hF);
    checkValue("post_reset_addr", out_addr, 32'd0);
    lpcCycle(4'h4, 32'hcafe0123, 8'h81, 0, 4'h0, 1'b0);
    checkDrained("post_reset_strobe");
    applyStimulus(1'b1, 4'hF);
    checkValue("strobe_one_clock", 32'(out_clock_enable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
